drive_sequencer: RTL and testbench
==================================

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 SHALL have parameter PWM_W, default 8, PWM counter width in bits.
REQ-002 SHALL have parameter CNT_W, default 27, maneuver tick counter width.
REQ-003 SHALL have parameter STRAIGHT_TICKS, default 5_000_000, junction straight-through duration in cycles.
REQ-004 SHALL have parameter TURN_TICKS, default 75_000_000, junction pivot duration in cycles.
REQ-005 SHALL have parameter BACK_TICKS, default 50_000_000, reverse-out duration in cycles.
REQ-006 SHALL have parameter RAMP_DIV, default 1024, cycles per duty step (used only with DRIVE_RAMP_EN).
REQ-007 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-008 SHALL have colDetect (in, 1, low = obstacle present).
REQ-009 SHALL have dirControl (in, 4, [3:2] heading 00 PROCEED/01 LEFT/10 RIGHT/11 STOP; [1:0] 01 VEER/10 HARD/11 PIVOT).
REQ-010 SHALL have tdValid (in, 1) and tdDir (in, 3, 000 STOP/001 STRAIGHT/010 LEFT/011 RIGHT/100 BACK) as the junction decision.
REQ-011 SHALL have jncReq (out, 1, high while awaiting a decision) and jncDone (out, 1, one-cycle pulse on maneuver completion).
REQ-012 SHALL have hbIn (out, 4, H-bridge inputs), hbEnA and hbEnB (out, 1 each, PWM enables).
REQ-013 SHALL have state (out, 3, current state code).

Function
REQ-014 SHALL implement states DRIVE=0, JNC_WAIT=1, JNC_STRAIGHT=2, JNC_TURN=3, JNC_EXIT=4, JNC_BACK=5, HALT=6.
REQ-015 SHALL generate enables from a free-running PWM_W-bit counter: enable = counter < duty, duty PWM_W+1 bits; FULL = 2^PWM_W (constant high), 0 = constant low.
REQ-016 SHALL scale duties in 1/16 units: FULL 16, VEER 8, HARD 12, NINETY 6, NINETY_FAST 12.
REQ-017 DRIVE (A,B,pattern): LEFT+VEER (VEER,FULL,STRAIGHT); LEFT+HARD (VEER,HARD,LEFT); LEFT+PIVOT (NINETY,NINETY_FAST,LEFT); RIGHT mirrored; PROCEED+00 (FULL,FULL,STRAIGHT); other codes hold previous outputs.
REQ-018 DRIVE SHALL go to JNC_WAIT when heading = STOP: duties 0, hbIn = STOP pattern.
REQ-019 JNC_WAIT and HALT SHALL assert jncReq and capture tdDir when tdValid=1: STOP->HALT, STRAIGHT->JNC_STRAIGHT, LEFT/RIGHT->JNC_TURN, BACK->JNC_BACK, codes 101-111->DRIVE with reverse flag cleared.
REQ-020 JNC_STRAIGHT SHALL drive (FULL,FULL,STRAIGHT) for exactly STRAIGHT_TICKS cycles, clear reverse flag, return to DRIVE.
REQ-021 JNC_TURN SHALL pivot (NINETY/NINETY_FAST as REQ-017 PIVOT, captured side) for exactly TURN_TICKS cycles, then JNC_EXIT.
REQ-022 JNC_EXIT SHALL drive (FULL,FULL,STRAIGHT) until heading != STOP, then DRIVE.
REQ-023 JNC_BACK SHALL toggle reverse flag on entry, drive (FULL,FULL,STRAIGHT) for exactly BACK_TICKS cycles, return to DRIVE.
REQ-024 While reverse flag set, every non-STOP pattern SHALL be bitwise inverted.
REQ-025 jncDone SHALL pulse the cycle DRIVE is re-entered from JNC_STRAIGHT, JNC_EXIT or JNC_BACK.
REQ-026 colDetect=0 in any motion state SHALL force both enables low within 1 cycle and freeze tick counter and state; release resumes at the frozen count.
REQ-027 tdValid coincident with colDetect=0 in JNC_WAIT SHALL still be accepted; the entered state starts paused.
REQ-028 Output latency SHALL be one cycle from state/input change to registered hbIn/enables.

Reset
REQ-029 rst SHALL set state DRIVE, reverse flag 0, counters 0, hbIn 0000, hbEnA/hbEnB/jncReq/jncDone 0.
REQ-030 rst mid-maneuver SHALL abandon it with no jncDone pulse.

Configuration
REQ-031 With DRIVE_RAMP_EN defined, applied duty SHALL move toward target by 1 every RAMP_DIV cycles on increase and drop immediately on decrease; undefined, duty applies immediately.

Structure
REQ-032 Shared package SHALL hold state codes, DC_/TD_ codes, duty ratios, HB_STRAIGHT=1010, HB_LEFT=1001, HB_RIGHT=0110, HB_STOP=0000.
REQ-033 SHALL instantiate one sub-module drive_pwm (counter, compare, optional ramp) per channel.

Verification (PWM_W=4, STRAIGHT_TICKS=8, TURN_TICKS=12, BACK_TICKS=6)
REQ-034 dirControl=0000 -> hbIn=1010, hbEnA/B constant high.
REQ-035 dirControl=0101 -> hbEnA high 8 of 16 cycles, hbEnB constant high, hbIn=1010.
REQ-036 dirControl=1100, tdValid with tdDir=010 -> pivot hbIn=1001 for 12 cycles, then 1010 until dirControl=0000, jncDone pulse.
REQ-037 tdDir=100 -> 6 cycles, then DRIVE with dirControl=0000 gives hbIn=0101.
REQ-038 colDetect=0 at tick 5 of JNC_STRAIGHT for 20 cycles -> enables low, exit 3 cycles after release.

Source files
------------

// File: rtl/drive_sequencer_pkg.sv
// Shared definitions for the drive sequencer: state codes, dirControl and
// junction-decision (tdDir) codes, duty ratios in 1/16 units, and H-bridge
// input patterns.
package drive_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DRIVE        = 3'd0,
    ST_JNC_WAIT     = 3'd1,
    ST_JNC_STRAIGHT = 3'd2,
    ST_JNC_TURN     = 3'd3,
    ST_JNC_EXIT     = 3'd4,
    ST_JNC_BACK     = 3'd5,
    ST_HALT         = 3'd6
  } state_e;

  // dirControl[3:2] heading
  localparam logic [1:0] DC_PROCEED = 2'b00;
  localparam logic [1:0] DC_LEFT    = 2'b01;
  localparam logic [1:0] DC_RIGHT   = 2'b10;
  localparam logic [1:0] DC_STOP    = 2'b11;
  // dirControl[1:0] steering severity
  localparam logic [1:0] DC_VEER    = 2'b01;
  localparam logic [1:0] DC_HARD    = 2'b10;
  localparam logic [1:0] DC_PIVOT   = 2'b11;

  // junction decision codes
  localparam logic [2:0] TD_STOP     = 3'b000;
  localparam logic [2:0] TD_STRAIGHT = 3'b001;
  localparam logic [2:0] TD_LEFT     = 3'b010;
  localparam logic [2:0] TD_RIGHT    = 3'b011;
  localparam logic [2:0] TD_BACK     = 3'b100;

  // duty ratios, sixteenths of full scale
  localparam int RATIO_FULL        = 16;
  localparam int RATIO_VEER        = 8;
  localparam int RATIO_HARD        = 12;
  localparam int RATIO_NINETY      = 6;
  localparam int RATIO_NINETY_FAST = 12;

  localparam logic [3:0] HB_STRAIGHT = 4'b1010;
  localparam logic [3:0] HB_LEFT     = 4'b1001;
  localparam logic [3:0] HB_RIGHT    = 4'b0110;
  localparam logic [3:0] HB_STOP     = 4'b0000;

  // States in which the wheels may be turning; a collision pauses these.
  function automatic logic is_motion(state_e s);
    return !(s == ST_JNC_WAIT || s == ST_HALT);
  endfunction

endpackage

// File: rtl/drive_sequencer_pwm.sv
// drive_pwm: one PWM channel. Free-running PWM_W-bit counter compared
// against a PWM_W+1-bit duty; duty 2^PWM_W gives a constant-high enable,
// duty 0 a constant-low enable. The enable is registered, so it follows a
// change of duty_tgt on the next clock edge.
// Optional feature macro: DRIVE_RAMP_EN -- applied duty climbs toward the
// target by 1 every RAMP_DIV cycles and drops to it immediately.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   duty_tgt      target duty (PWM_W+1 bits)
//   en            registered PWM enable
module drive_pwm
  import drive_sequencer_pkg::*;
#(
  parameter int PWM_W    = 8,
  parameter int RAMP_DIV = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PWM_W:0] duty_tgt,
  output logic           en
);

`ifdef DRIVE_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PWM_W:0]   duty_q, duty_d, duty_eff;
  logic             en_q, en_d;

  // With the ramp disabled RAMP_EN is constant 0 and the ramp state folds
  // away, leaving the target duty applied directly.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    duty_d = duty_q;
    if (duty_tgt < duty_q)
      duty_d = duty_tgt;
    else if (duty_tgt > duty_q && div_q == DIV_LAST)
      duty_d = duty_q + 1'b1;
    duty_eff = RAMP_EN ? duty_d : duty_tgt;
    // compare against the counter value that will be live after this edge
    en_d = ({1'b0, cnt_d} < duty_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= '0;
      duty_q <= '0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      duty_q <= duty_d;
      en_q   <= en_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/drive_sequencer.sv
// drive_sequencer: line-follower drive sequencer. Decodes dirControl into
// H-bridge patterns and per-side PWM duties, stops at junctions, waits for a
// decision (tdValid/tdDir) and runs timed straight/turn/back maneuvers.
// A collision (colDetect low) pauses any motion state: enables drop, state
// and tick counter freeze. Optional macro DRIVE_RAMP_EN enables duty ramping
// inside drive_pwm.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   colDetect            low = obstacle present
//   dirControl[3:0]      [3:2] heading, [1:0] severity
//   tdValid, tdDir[2:0]  junction decision
//   jncReq, jncDone      awaiting decision / maneuver-complete pulse
//   hbIn[3:0]            H-bridge inputs
//   hbEnA, hbEnB         PWM enables
//   state[2:0]           current state code
module drive_sequencer
  import drive_sequencer_pkg::*;
#(
  parameter int PWM_W          = 8,
  parameter int CNT_W          = 27,
  parameter int STRAIGHT_TICKS = 5_000_000,
  parameter int TURN_TICKS     = 75_000_000,
  parameter int BACK_TICKS     = 50_000_000,
  parameter int RAMP_DIV       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       colDetect,
  input  logic [3:0] dirControl,
  input  logic       tdValid,
  input  logic [2:0] tdDir,
  output logic       jncReq,
  output logic       jncDone,
  output logic [3:0] hbIn,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic [2:0] state
);

  localparam int DW = PWM_W + 1;
  localparam logic [PWM_W:0] D_FULL   = DW'(RATIO_FULL        * (2**PWM_W) / 16);
  localparam logic [PWM_W:0] D_VEER   = DW'(RATIO_VEER        * (2**PWM_W) / 16);
  localparam logic [PWM_W:0] D_HARD   = DW'(RATIO_HARD        * (2**PWM_W) / 16);
  localparam logic [PWM_W:0] D_N90    = DW'(RATIO_NINETY      * (2**PWM_W) / 16);
  localparam logic [PWM_W:0] D_N90F   = DW'(RATIO_NINETY_FAST * (2**PWM_W) / 16);

  localparam logic [CNT_W-1:0] STR_LAST  = CNT_W'(STRAIGHT_TICKS - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_TICKS - 1);
  localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             rev_q, rev_d;
  logic             side_q, side_d;   // captured turn side, 1 = right
  logic             done_q, done_d;
  logic [3:0]       hb_q, hb_d;
  logic [PWM_W:0]   duty_a_q, duty_a_d, duty_b_q, duty_b_d;
  logic [PWM_W:0]   app_a, app_b;
  logic [3:0]       pat;
  logic             load;
  logic             paused;
  logic [1:0]       heading, mode;

  assign heading = dirControl[3:2];
  assign mode    = dirControl[1:0];
  assign paused  = !colDetect && is_motion(state_q);

  // next state, tick counter, flags
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rev_d   = rev_q;
    side_d  = side_q;
    done_d  = 1'b0;
    case (state_q)
      ST_DRIVE:
        if (!paused && heading == DC_STOP) state_d = ST_JNC_WAIT;
      ST_JNC_WAIT, ST_HALT:
        // decisions are taken even during a collision; the maneuver state
        // then simply starts out paused
        if (tdValid) begin
          tick_d = '0;
          case (tdDir)
            TD_STOP:     state_d = ST_HALT;
            TD_STRAIGHT: begin state_d = ST_JNC_STRAIGHT; rev_d = 1'b0; end
            TD_LEFT:     begin state_d = ST_JNC_TURN; side_d = 1'b0; end
            TD_RIGHT:    begin state_d = ST_JNC_TURN; side_d = 1'b1; end
            TD_BACK:     begin state_d = ST_JNC_BACK; rev_d = ~rev_q; end
            default:     begin state_d = ST_DRIVE; rev_d = 1'b0; end
          endcase
        end
      ST_JNC_STRAIGHT:
        if (!paused) begin
          if (tick_q == STR_LAST) begin
            state_d = ST_DRIVE; tick_d = '0; done_d = 1'b1;
          end else tick_d = tick_q + 1'b1;
        end
      ST_JNC_TURN:
        if (!paused) begin
          if (tick_q == TURN_LAST) begin
            state_d = ST_JNC_EXIT; tick_d = '0;
          end else tick_d = tick_q + 1'b1;
        end
      ST_JNC_EXIT:
        if (!paused && heading != DC_STOP) begin
          state_d = ST_DRIVE; done_d = 1'b1;
        end
      ST_JNC_BACK:
        if (!paused) begin
          if (tick_q == BACK_LAST) begin
            state_d = ST_DRIVE; tick_d = '0; done_d = 1'b1;
          end else tick_d = tick_q + 1'b1;
        end
      default: state_d = ST_DRIVE;
    endcase
  end

  // outputs are decoded for the state being entered so they line up with
  // the registered state code
  always_comb begin
    hb_d     = hb_q;
    duty_a_d = duty_a_q;
    duty_b_d = duty_b_q;
    pat      = HB_STOP;
    load     = 1'b0;
    if (!paused) begin
      case (state_d)
        ST_DRIVE:
          case (heading)
            DC_PROCEED:
              if (mode == 2'b00) begin
                load = 1'b1; pat = HB_STRAIGHT; duty_a_d = D_FULL; duty_b_d = D_FULL;
              end
            DC_LEFT:
              case (mode)
                DC_VEER:  begin load = 1'b1; pat = HB_STRAIGHT; duty_a_d = D_VEER; duty_b_d = D_FULL; end
                DC_HARD:  begin load = 1'b1; pat = HB_LEFT;     duty_a_d = D_VEER; duty_b_d = D_HARD; end
                DC_PIVOT: begin load = 1'b1; pat = HB_LEFT;     duty_a_d = D_N90;  duty_b_d = D_N90F; end
                default: ;
              endcase
            DC_RIGHT:
              case (mode)
                DC_VEER:  begin load = 1'b1; pat = HB_STRAIGHT; duty_a_d = D_FULL; duty_b_d = D_VEER; end
                DC_HARD:  begin load = 1'b1; pat = HB_RIGHT;    duty_a_d = D_HARD; duty_b_d = D_VEER; end
                DC_PIVOT: begin load = 1'b1; pat = HB_RIGHT;    duty_a_d = D_N90F; duty_b_d = D_N90;  end
                default: ;
              endcase
            default: begin load = 1'b1; pat = HB_STOP; duty_a_d = '0; duty_b_d = '0; end
          endcase
        ST_JNC_STRAIGHT, ST_JNC_EXIT, ST_JNC_BACK: begin
          load = 1'b1; pat = HB_STRAIGHT; duty_a_d = D_FULL; duty_b_d = D_FULL;
        end
        ST_JNC_TURN:
          if (side_d) begin
            load = 1'b1; pat = HB_RIGHT; duty_a_d = D_N90F; duty_b_d = D_N90;
          end else begin
            load = 1'b1; pat = HB_LEFT;  duty_a_d = D_N90;  duty_b_d = D_N90F;
          end
        default: begin load = 1'b1; pat = HB_STOP; duty_a_d = '0; duty_b_d = '0; end
      endcase
    end
    // reverse swaps every motor's polarity; STOP stays all-off
    if (load) hb_d = (rev_d && pat != HB_STOP) ? ~pat : pat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DRIVE;
      tick_q   <= '0;
      rev_q    <= 1'b0;
      side_q   <= 1'b0;
      done_q   <= 1'b0;
      hb_q     <= HB_STOP;
      duty_a_q <= '0;
      duty_b_q <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      rev_q    <= rev_d;
      side_q   <= side_d;
      done_q   <= done_d;
      hb_q     <= hb_d;
      duty_a_q <= duty_a_d;
      duty_b_q <= duty_b_d;
    end
  end

  // collision gates the applied duty directly so enables drop on the next edge
  assign app_a = colDetect ? duty_a_d : '0;
  assign app_b = colDetect ? duty_b_d : '0;

  drive_pwm #(.PWM_W(PWM_W), .RAMP_DIV(RAMP_DIV)) u_pwm_a (
    .clk(clk), .rst(rst), .duty_tgt(app_a), .en(hbEnA)
  );
  drive_pwm #(.PWM_W(PWM_W), .RAMP_DIV(RAMP_DIV)) u_pwm_b (
    .clk(clk), .rst(rst), .duty_tgt(app_b), .en(hbEnB)
  );

  assign hbIn    = hb_q;
  assign state   = state_q;
  assign jncReq  = (state_q == ST_JNC_WAIT) || (state_q == ST_HALT);
  assign jncDone = done_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: stimulus queues expected snapshots
// tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       colDetect = 1'b1;
  logic [3:0] dirControl = 4'b0000;
  logic       tdValid = 1'b0;
  logic [2:0] tdDir = 3'b000;
  logic       jncReq, jncDone, hbEnA, hbEnB;
  logic [3:0] hbIn;
  logic [2:0] state;

  drive_sequencer #(
    .PWM_W(4), .CNT_W(8), .STRAIGHT_TICKS(8), .TURN_TICKS(12),
    .BACK_TICKS(6), .RAMP_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .colDetect(colDetect), .dirControl(dirControl),
    .tdValid(tdValid), .tdDir(tdDir), .jncReq(jncReq), .jncDone(jncDone),
    .hbIn(hbIn), .hbEnA(hbEnA), .hbEnB(hbEnB), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string nm;
    int    st, hb, ea, eb, req, done, ca, cb, dc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [15:0] hist_a = '0, hist_b = '0;
  bit          end_req = 1'b0;
  bit          final_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit fok(int e, int a);
    return (e < 0) || (e == a);
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] na, nb;
    int          ca, cb, dn;
    bit          ok;
    na = {hist_a[14:0], hbEnA};
    nb = {hist_b[14:0], hbEnB};
    hist_a <= na;
    hist_b <= nb;
    ca = $countones(na);
    cb = $countones(nb);
    dn = done_seen + (jncDone ? 1 : 0);
    done_seen <= dn;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ok = (e.cyc == cyc) && fok(e.st, int'(state)) && fok(e.hb, int'(hbIn)) &&
           fok(e.ea, int'(hbEnA)) && fok(e.eb, int'(hbEnB)) &&
           fok(e.req, int'(jncReq)) && fok(e.done, int'(jncDone)) &&
           fok(e.ca, ca) && fok(e.cb, cb) && fok(e.dc, dn);
      checks <= checks + 1;
      if (!ok) begin
        errors <= errors + 1;
        $display("FAIL %s cyc=%0d(want %0d): got st=%0d hb=%b enA=%b enB=%b req=%b done=%b cntA=%0d cntB=%0d dones=%0d; want st=%0d hb=%0d enA=%0d enB=%0d req=%0d done=%0d cntA=%0d cntB=%0d dones=%0d (-1 any)",
                 e.nm, cyc, e.cyc, state, hbIn, hbEnA, hbEnB, jncReq, jncDone, ca, cb, dn,
                 e.st, e.hb, e.ea, e.eb, e.req, e.done, e.ca, e.cb, e.dc);
      end
    end
    if (end_req && !final_done) begin
      final_done <= 1'b1;
      if (q.size() != 0) begin
        $display("FAIL leftover_expectations: got %0d pending, want 0", q.size());
        errors <= errors + 1;
      end
      checks <= checks + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input int ofs, input string nm, input int st, input int hb,
                     input int ea, input int eb, input int req, input int done,
                     input int ca = -1, input int cb = -1, input int dc = -1);
    exp_t e;
    e.cyc = cyc + ofs; e.nm = nm; e.st = st; e.hb = hb; e.ea = ea; e.eb = eb;
    e.req = req; e.done = done; e.ca = ca; e.cb = cb; e.dc = dc;
    q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    step(3);
    chk(0, "reset", 0, 'b0000, 0, 0, 0, 0);
    rst = 1'b0;
    // straight ahead, both sides full
    chk(1, "drive_fwd", 0, 'b1010, 1, 1, 0, 0);
    step(20);
    chk(0, "fwd_duty", 0, 'b1010, 1, 1, 0, 0, 16, 16);
    // left veer: A half duty
    dirControl = 4'b0101;
    chk(1, "veer_first", 0, 'b1010, -1, 1, 0, 0);
    step(17);
    chk(0, "veer_duty", 0, 'b1010, -1, 1, 0, 0, 8, 16);
    // left hard
    dirControl = 4'b0110;
    chk(1, "hard_first", 0, 'b1001, -1, -1, 0, 0);
    step(17);
    chk(0, "hard_duty", 0, 'b1001, -1, -1, 0, 0, 8, 12);
    // right pivot
    dirControl = 4'b1011;
    step(17);
    chk(0, "rpivot_duty", 0, 'b0110, -1, -1, 0, 0, 12, 6);
    // undefined code holds previous outputs
    dirControl = 4'b0001;
    chk(1, "hold_hb", 0, 'b0110, -1, -1, 0, 0);
    step(17);
    chk(0, "hold_duty", 0, 'b0110, -1, -1, 0, 0, 12, 6);
    dirControl = 4'b0000;
    chk(1, "fwd_again", 0, 'b1010, 1, 1, 0, 0);
    step(2);
    // junction, left turn
    dirControl = 4'b1100;
    chk(1, "wait", 1, 'b0000, 0, 0, 1, 0);
    step(3);
    chk(0, "wait_hold", 1, 'b0000, 0, 0, 1, 0);
    tdValid = 1'b1; tdDir = 3'b010;
    chk(1, "turn_in", 3, 'b1001, -1, -1, 0, 0);
    step(1);
    tdValid = 1'b0;
    chk(11, "turn_last", 3, 'b1001, -1, -1, 0, 0);
    chk(12, "exit", 4, 'b1010, 1, 1, 0, 0);
    step(15);
    chk(0, "exit_hold", 4, 'b1010, 1, 1, 0, 0);
    dirControl = 4'b0000;
    chk(1, "done_turn", 0, 'b1010, 1, 1, 0, 1);
    chk(2, "done_clr", 0, 'b1010, 1, 1, 0, 0);
    step(2);
    // back out: reverse flag set
    dirControl = 4'b1100;
    chk(1, "wait_b", 1, 'b0000, 0, 0, 1, 0);
    step(1);
    tdValid = 1'b1; tdDir = 3'b100;
    chk(1, "back_in", 5, 'b0101, 1, 1, 0, 0);
    step(1);
    tdValid = 1'b0; dirControl = 4'b0000;
    chk(5, "back_last", 5, 'b0101, 1, 1, 0, 0);
    chk(6, "back_done", 0, 'b0101, 1, 1, 0, 1);
    step(8);
    dirControl = 4'b0110;
    chk(1, "rev_hard", 0, 'b0110, -1, -1, 0, 0);
    step(3);
    // straight maneuver with collision at tick 5
    dirControl = 4'b1100;
    chk(1, "wait_s", 1, 'b0000, 0, 0, 1, 0);
    step(1);
    tdValid = 1'b1; tdDir = 3'b001;
    chk(1, "str_in", 2, 'b1010, 1, 1, 0, 0);
    step(1);
    tdValid = 1'b0; dirControl = 4'b0000;
    step(5);
    colDetect = 1'b0;
    chk(1, "col_off", 2, 'b1010, 0, 0, 0, 0);
    step(20);
    chk(0, "col_hold", 2, 'b1010, 0, 0, 0, 0, 0, 0);
    colDetect = 1'b1;
    chk(1, "col_rel", 2, 'b1010, 1, 1, 0, 0);
    chk(2, "col_rel2", 2, 'b1010, 1, 1, 0, 0);
    chk(3, "str_done", 0, 'b1010, 1, 1, 0, 1);
    step(4);
    // decision accepted during collision; turn starts paused
    dirControl = 4'b1100;
    chk(1, "wait_c", 1, 'b0000, 0, 0, 1, 0);
    step(1);
    tdValid = 1'b1; tdDir = 3'b011; colDetect = 1'b0;
    chk(1, "col_turn", 3, 'b0110, 0, 0, 0, 0);
    step(1);
    tdValid = 1'b0;
    step(3);
    chk(0, "col_turn_hold", 3, 'b0110, 0, 0, 0, 0);
    colDetect = 1'b1;
    chk(1, "turn_go", 3, 'b0110, -1, -1, 0, 0);
    chk(11, "col_turn_last", 3, 'b0110, -1, -1, 0, 0);
    chk(12, "col_turn_exit", 4, 'b1010, 1, 1, 0, 0);
    step(12);
    dirControl = 4'b0000;
    chk(1, "done_col_turn", 0, 'b1010, 1, 1, 0, 1);
    step(2);
    // halt, then leave via an undefined decision code (no jncDone)
    dirControl = 4'b1100;
    step(1);
    tdValid = 1'b1; tdDir = 3'b000;
    chk(1, "halt", 6, 'b0000, 0, 0, 1, 0);
    step(1);
    tdValid = 1'b0;
    step(2);
    chk(0, "halt_hold", 6, 'b0000, 0, 0, 1, 0);
    dirControl = 4'b0000; tdValid = 1'b1; tdDir = 3'b111;
    chk(1, "halt_exit", 0, 'b1010, 1, 1, 0, 0);
    step(1);
    tdValid = 1'b0;
    step(2);
    // reset mid-maneuver abandons it without jncDone
    dirControl = 4'b1100;
    step(1);
    tdValid = 1'b1; tdDir = 3'b001;
    step(1);
    tdValid = 1'b0;
    step(3);
    rst = 1'b1;
    chk(0, "rst_mid", 0, 'b0000, 0, 0, 0, 0);
    step(2);
    dirControl = 4'b0000; rst = 1'b0;
    chk(1, "post_rst", 0, 'b1010, 1, 1, 0, 0);
    step(12);
    chk(0, "done_total", 0, 'b1010, 1, 1, 0, 0, -1, -1, 4);
    step(2);
    end_req = 1'b1;
    step(2);
    if (!final_done) step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
